mem_arbiter: RTL and testbench

Two-port round-robin arbiter sharing the single byte-addressed memory (en/rw/abus/dbus interface) between the CPU control unit (port 0) and a DMA/debug loader (port 1). It serialises word accesses, holds the memory enable for a programmable number of cycles, returns read data with a one-cycle ack, and rejects out-of-range addresses without touching memory.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of the shared byte memory.
// Ports: clock/reset; per requester p*_req/rw/addr/wdata in, p*_ack/err/rdata out;
// gnt one-hot owner; m_en/m_rw/m_addr/m_wdata to memory, m_rdata from memory.
module mem_arbiter #(
    parameter int          LAT     = 1,
    parameter logic [31:0] MEM_TOP = 32'd124
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_rw,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_rw,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [1:0]  gnt,
    output logic        m_en,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t      state_q;
    logic        last_q;
    logic [3:0]  cnt_q;

    logic        win_d;
    logic        rw_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic        in_range_d;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        win_d      = (p0_req && p1_req) ? ~last_q : p1_req;
        rw_d       = win_d ? p1_rw    : p0_rw;
        addr_d     = win_d ? p1_addr  : p0_addr;
        wdata_d    = win_d ? p1_wdata : p0_wdata;
        in_range_d = (addr_d <= MEM_TOP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= 4'd0;
            gnt      <= 2'b00;
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p0_rdata <= 32'd0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= 32'd0;
            m_en     <= 1'b0;
            m_rw     <= 1'b1;
            m_addr   <= 32'd0;
            m_wdata  <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        last_q <= win_d;
                        gnt    <= win_d ? 2'b10 : 2'b01;
                        if (!in_range_d) begin
                            // Rejected without ever driving the memory bus.
                            state_q <= DONE;
                            p0_err  <= ~win_d;
                            p1_err  <= win_d;
                        end else begin
                            state_q <= ACCESS;
                            m_en    <= 1'b1;
                            m_rw    <= rw_d;
                            m_addr  <= addr_d;
                            m_wdata <= wdata_d;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        m_en    <= 1'b0;
                        m_rw    <= 1'b1;
                        // m_rw still holds the latched direction here.
                        if (gnt[1]) begin
                            p1_ack <= 1'b1;
                            if (m_rw) p1_rdata <= m_rdata;
                        end else begin
                            p0_ack <= 1'b1;
                            if (m_rw) p0_rdata <= m_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt     <= 2'b00;
                    p0_ack  <= 1'b0;
                    p0_err  <= 1'b0;
                    p1_ack  <= 1'b0;
                    p1_err  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a big-endian byte memory.
// A LAT=1 instance carries most traffic; a LAT=3 instance checks access length.
module tb_mem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        p0_req, p0_rw, p0_ack, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_rw, p1_ack, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [1:0]  gnt;
    logic        m_en, m_rw;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic        q_req, q_ack, q_err, q1_ack, q1_err;
    logic [31:0] q_addr, q_rdata, q1_rdata;
    logic [1:0]  q_gnt;
    logic        q_en, q_rw;
    logic [31:0] q_maddr, q_mwdata, q_mrdata;

    logic [7:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    mem_arbiter #(.LAT(1), .MEM_TOP(32'd124)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err),
        .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err),
        .p1_rdata(p1_rdata),
        .gnt(gnt), .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    mem_arbiter #(.LAT(3), .MEM_TOP(32'd124)) u3 (
        .clock(clock), .reset(reset),
        .p0_req(q_req), .p0_rw(1'b1), .p0_addr(q_addr),
        .p0_wdata(32'd0), .p0_ack(q_ack), .p0_err(q_err),
        .p0_rdata(q_rdata),
        .p1_req(1'b0), .p1_rw(1'b1), .p1_addr(32'd0),
        .p1_wdata(32'd0), .p1_ack(q1_ack), .p1_err(q1_err),
        .p1_rdata(q1_rdata),
        .gnt(q_gnt), .m_en(q_en), .m_rw(q_rw), .m_addr(q_maddr),
        .m_wdata(q_mwdata), .m_rdata(q_mrdata)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        logic [6:0] b;
        b = a[6:0];
        return {mem[b], mem[b + 7'd1], mem[b + 7'd2], mem[b + 7'd3]};
    endfunction

    always_comb m_rdata  = rd(m_addr);
    always_comb q_mrdata = rd(q_maddr);

    // Memory contents are (re)loaded on every reset; only dut writes.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
            {mem[0], mem[1], mem[2], mem[3]}         <= 32'h001F0018;
            {mem[4], mem[5], mem[6], mem[7]}         <= 32'hDEADBEEF;
            {mem[8], mem[9], mem[10], mem[11]}       <= 32'h12345678;
            {mem[32], mem[33], mem[34], mem[35]}     <= 32'hFFFFFFFF;
            {mem[124], mem[125], mem[126], mem[127]} <= 32'hA1B2C3D4;
        end else if (m_en && !m_rw) begin
            mem[m_addr[6:0]]         <= m_wdata[31:24];
            mem[m_addr[6:0] + 7'd1]  <= m_wdata[23:16];
            mem[m_addr[6:0] + 7'd2]  <= m_wdata[15:8];
            mem[m_addr[6:0] + 7'd3]  <= m_wdata[7:0];
        end
    end

    task automatic check(input string n, input logic [31:0] a,
                         input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    task automatic pop_cmp(input logic port, input logic ack,
                           input logic err, input logic [31:0] rdata);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected port %0d ack %0d err %0d",
                     port, ack, err);
        end else begin
            e = sbq.pop_front();
            check("sb_port", 32'(port), 32'(e.port));
            check("sb_err", 32'(err), 32'(e.err));
            check("sb_ack", 32'(ack), 32'(!e.err));
            check("sb_rdata", rdata, e.rdata);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("one_resp", 32'((p0_ack | p0_err) & (p1_ack | p1_err)), 0);
            if (p0_ack | p0_err) pop_cmp(1'b0, p0_ack, p0_err, p0_rdata);
            if (p1_ack | p1_err) pop_cmp(1'b1, p1_ack, p1_err, p1_rdata);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_resp(input logic port, input logic err,
                               input logic [31:0] rdata);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rdata;
        sbq.push_back(e);
    endtask

    task automatic xact(input logic port, input logic rw,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        bit done;
        done = 0;
        expect_resp(port, exp_err, exp_rd);
        if (port) begin
            p1_req = 1; p1_rw = rw; p1_addr = addr; p1_wdata = wd;
        end else begin
            p0_req = 1; p0_rw = rw; p0_addr = addr; p0_wdata = wd;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (port ? (p1_ack | p1_err) : (p0_ack | p0_err)) done = 1;
        end
        check("xact_done", 32'(done), 1);
        p0_req = 0;
        p1_req = 0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, en_cnt, first_en, ack_at;
        reset = 1;
        p0_req = 0; p0_rw = 1; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_rw = 1; p1_addr = 0; p1_wdata = 0;
        q_req = 0; q_addr = 0;
        tick(); tick(); tick();
        reset = 0;

        check("rst_gnt", 32'(gnt), 0);
        check("rst_m_en", 32'(m_en), 0);
        check("rst_m_rw", 32'(m_rw), 1);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_p0_rdata", p0_rdata, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        check("rst_acks", 32'({p0_ack, p0_err, p1_ack, p1_err}), 0);

        // LAT=1 read with cycle-exact timing
        expect_resp(1'b0, 1'b0, 32'h001F0018);
        p0_req = 1; p0_rw = 1; p0_addr = 0;
        tick();
        check("t1_en", 32'(m_en), 1);
        check("t1_addr", m_addr, 0);
        check("t1_gnt", 32'(gnt), 1);
        check("t1_noack", 32'(p0_ack), 0);
        tick();
        check("t1_en_off", 32'(m_en), 0);
        check("t1_ack", 32'(p0_ack), 1);
        check("t1_gnt_ack", 32'(gnt), 1);
        p0_req = 0;
        tick();
        check("t1_gnt_idle", 32'(gnt), 0);
        check("t1_ack_off", 32'(p0_ack), 0);

        // port 1 write then port 0 read back, plus top-of-range read
        xact(1'b1, 1'b0, 32'h20, 32'h0000002A, 32'h0, 1'b0);
        check("t2_mem", rd(32'h20), 32'h0000002A);
        xact(1'b0, 1'b1, 32'h20, 32'h0, 32'h0000002A, 1'b0);
        xact(1'b0, 1'b1, 32'd124, 32'h0, 32'hA1B2C3D4, 1'b0);

        // tie from reset: grants must alternate 0,1,0,1
        reset = 1;
        tick(); tick();
        reset = 0;
        expect_resp(1'b0, 1'b0, 32'h001F0018);
        expect_resp(1'b1, 1'b0, 32'hDEADBEEF);
        expect_resp(1'b0, 1'b0, 32'h001F0018);
        expect_resp(1'b1, 1'b0, 32'hDEADBEEF);
        p0_req = 1; p0_rw = 1; p0_addr = 0;
        p1_req = 1; p1_rw = 1; p1_addr = 4;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 100 && !(n0 == 2 && n1 == 2); i++) begin
            tick();
            if (p0_ack) begin
                n0++;
                if (n0 == 2) p0_req = 0;
            end
            if (p1_ack) begin
                n1++;
                if (n1 == 2) p1_req = 0;
            end
        end
        check("t3_done", 32'(n0 == 2 && n1 == 2), 1);
        p0_req = 0; p1_req = 0;
        tick();

        // out-of-range port 1 read: err next cycle, memory untouched
        expect_resp(1'b1, 1'b1, 32'hDEADBEEF);
        p1_req = 1; p1_rw = 1; p1_addr = 32'd125;
        tick();
        check("t5_err", 32'(p1_err), 1);
        check("t5_ack", 32'(p1_ack), 0);
        check("t5_en", 32'(m_en), 0);
        check("t5_gnt", 32'(gnt), 2);
        p1_req = 0;
        tick();
        check("t5_en2", 32'(m_en), 0);
        check("t5_err_off", 32'(p1_err), 0);
        tick();

        // reset during access after port 0 won; next tie goes to port 0
        p0_req = 1; p0_rw = 1; p0_addr = 0;
        tick();
        check("t6_en", 32'(m_en), 1);
        reset = 1;
        p0_req = 0;
        tick();
        check("t6_noack", 32'(p0_ack), 0);
        check("t6_en_off", 32'(m_en), 0);
        check("t6_gnt", 32'(gnt), 0);
        reset = 0;
        expect_resp(1'b0, 1'b0, 32'h001F0018);
        p0_req = 1; p0_rw = 1; p0_addr = 0;
        p1_req = 1; p1_rw = 1; p1_addr = 4;
        tick();
        check("t6_tie", 32'(gnt), 1);
        n0 = 0;
        for (int i = 0; i < 20 && n0 == 0; i++) begin
            tick();
            if (p0_ack) n0 = 1;
        end
        check("t6_done", 32'(n0), 1);
        p0_req = 0; p1_req = 0;
        tick(); tick();

        // LAT=3 instance: enable exactly 3 cycles, ack in cycle N+4
        q_req = 1; q_addr = 8;
        en_cnt = 0; first_en = 0; ack_at = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (q_en) begin
                en_cnt++;
                if (first_en == 0) first_en = i;
            end
            if (q_ack && ack_at == 0) begin
                ack_at = i;
                q_req = 0;
            end
        end
        check("t4_en_cnt", 32'(en_cnt), 3);
        check("t4_first_en", 32'(first_en), 1);
        check("t4_ack_at", 32'(ack_at), 4);
        check("t4_rdata", q_rdata, 32'h12345678);

        check("sb_drain", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
